// File: rtl/servo_pwm_bank_if.sv
// Register-side write port of servo_pwm_bank: a one-cycle strobe carrying a
// channel index and a pulse width in UI.
interface servo_pwm_bank_if #(
    parameter int NUM_CH = 8,
    parameter int PW_W   = 12
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            wr_en;
    logic [CH_W-1:0] wr_ch;
    logic [PW_W-1:0] wr_data;

    modport master (output wr_en, wr_ch, wr_data);
    modport slave  (input  wr_en, wr_ch, wr_data);
endinterface

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator with shared UI prescaler/frame timer and
// frame-synchronous width commit. Define SERVO_PWM_SLEW_EN for per-frame slew limiting.
module servo_pwm_bank #(
    parameter int NUM_CH    = 8,
    parameter int PW_W      = 12,
    parameter int UI_DIV    = 100,
    parameter int FRAME_UI  = 20000,
    parameter int SLEW_STEP = 16
) (
    input  logic              clk,
    input  logic              rst,
    servo_pwm_bank_if.slave   wr,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              io_enb,
    output logic              sof,
    output logic [NUM_CH-1:0] ch_active,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] pwm_oe
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PS_W = $clog2(UI_DIV);
    localparam int FC_W = $clog2(FRAME_UI);
    // Clamp compare runs wide enough for both the shadow value and FRAME_UI-1.
    localparam int CW   = (PW_W > FC_W) ? PW_W : FC_W;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(UI_DIV - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_UI - 1);
    localparam logic [CW-1:0]   W_LIMIT = CW'(FRAME_UI - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } ch_state_t;

    logic [PS_W-1:0] presc_reg;
    logic [PS_W-1:0] presc_next;
    logic [FC_W-1:0] frame_reg;
    logic [FC_W-1:0] frame_next;
    logic            tick;

    assign tick = (presc_reg == PS_LAST);
    assign sof  = tick && (frame_reg == '0);

    always_comb begin
        presc_next = presc_reg + PS_W'(1);
        frame_next = frame_reg;
        if (tick) begin
            presc_next = '0;
            frame_next = (frame_reg == FC_LAST) ? '0 : frame_reg + FC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            frame_reg <= '0;
        end else begin
            presc_reg <= presc_next;
            frame_reg <= frame_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ch_state_t       state_reg;
            ch_state_t       state_next;
            logic [PW_W-1:0] shadow_reg;
            logic [PW_W-1:0] cnt_reg;
            logic [PW_W-1:0] cnt_next;
            logic [PW_W-1:0] clamp_w;
            logic [PW_W-1:0] commit_w;
            logic            active_reg;
            logic            active_next;
            logic            oe_reg;
            logic            oe_next;
            logic            pwm_reg;
            logic            wr_hit;

            // Indices at or beyond NUM_CH match no channel and are dropped.
            assign wr_hit  = wr.wr_en && (wr.wr_ch == CH_W'(gi));
            assign clamp_w = (CW'(shadow_reg) > W_LIMIT) ? PW_W'(W_LIMIT) : shadow_reg;

`ifdef SERVO_PWM_SLEW_EN
            localparam int STEP_C = (SLEW_STEP < (2**PW_W - 1)) ? SLEW_STEP : (2**PW_W - 1);
            localparam logic [PW_W-1:0] STEP_V = PW_W'(STEP_C);

            logic [PW_W-1:0] width_reg;
            logic [PW_W-1:0] up_diff;
            logic [PW_W-1:0] dn_diff;

            assign up_diff = clamp_w - width_reg;
            assign dn_diff = width_reg - clamp_w;

            // Step is applied only when the target is further than one step away,
            // so the result never overshoots and never wraps.
            always_comb begin
                commit_w = clamp_w;
                if (active_reg) begin
                    if ((clamp_w > width_reg) && (up_diff > STEP_V)) begin
                        commit_w = width_reg + STEP_V;
                    end else if ((clamp_w < width_reg) && (dn_diff > STEP_V)) begin
                        commit_w = width_reg - STEP_V;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    width_reg <= '0;
                end else if (sof) begin
                    width_reg <= commit_w;
                end
            end
`else
            assign commit_w = clamp_w;
`endif

            always_comb begin
                state_next  = state_reg;
                cnt_next    = cnt_reg;
                active_next = active_reg;
                oe_next     = oe_reg;
                if (sof) begin
                    active_next = ch_en[gi];
                    cnt_next    = commit_w;
                    state_next  = (ch_en[gi] && (commit_w != '0)) ? S_HIGH : S_IDLE;
                end else if (tick && (state_reg == S_HIGH)) begin
                    cnt_next = cnt_reg - PW_W'(1);
                    if (cnt_reg == PW_W'(1)) begin
                        state_next = S_LOW;
                    end
                end
                if (!io_enb) begin
                    oe_next = 1'b0;
                end else if (sof) begin
                    oe_next = ch_en[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg  <= S_IDLE;
                    shadow_reg <= '0;
                    cnt_reg    <= '0;
                    active_reg <= 1'b0;
                    oe_reg     <= 1'b0;
                    pwm_reg    <= 1'b0;
                end else begin
                    if (wr_hit) begin
                        shadow_reg <= wr.wr_data;
                    end
                    state_reg  <= state_next;
                    cnt_reg    <= cnt_next;
                    active_reg <= active_next;
                    oe_reg     <= oe_next;
                    pwm_reg    <= (state_next == S_HIGH);
                end
            end

            assign ch_active[gi] = active_reg;
            assign pwm_out[gi]   = pwm_reg;
            assign pwm_oe[gi]    = oe_reg;
        end
    endgenerate
endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: 4-channel bank plus a 3-channel bank that
// receives an out-of-range write. UI_DIV=4, FRAME_UI=50 (frame = 200 clks).
module tb_servo_pwm_bank;
    localparam int PW_W      = 12;
    localparam int UI_DIV    = 4;
    localparam int FRAME_UI  = 50;
    localparam int SLEW_STEP = 16;
`ifdef SERVO_PWM_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ch_en;
    logic       io_enb;
    logic       sof;
    logic [3:0] ch_active;
    logic [3:0] pwm_out;
    logic [3:0] pwm_oe;
    logic       sof3;
    logic [2:0] ch_active3;
    logic [2:0] pwm_out3;
    logic [2:0] pwm_oe3;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt;
    int hi_len[4];
    bit seen3 = 1'b0;

    servo_pwm_bank_if #(.NUM_CH(4), .PW_W(PW_W)) bus  ();
    servo_pwm_bank_if #(.NUM_CH(3), .PW_W(PW_W)) bus3 ();

    servo_pwm_bank #(
        .NUM_CH(4), .PW_W(PW_W), .UI_DIV(UI_DIV), .FRAME_UI(FRAME_UI), .SLEW_STEP(SLEW_STEP)
    ) dut (
        .clk(clk), .rst(rst), .wr(bus), .ch_en(ch_en), .io_enb(io_enb),
        .sof(sof), .ch_active(ch_active), .pwm_out(pwm_out), .pwm_oe(pwm_oe)
    );

    servo_pwm_bank #(
        .NUM_CH(3), .PW_W(PW_W), .UI_DIV(UI_DIV), .FRAME_UI(FRAME_UI), .SLEW_STEP(SLEW_STEP)
    ) dut3 (
        .clk(clk), .rst(rst), .wr(bus3), .ch_en(ch_en[2:0]), .io_enb(io_enb),
        .sof(sof3), .ch_active(ch_active3), .pwm_out(pwm_out3), .pwm_oe(pwm_oe3)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (pwm_out3 != 3'b0) seen3 <= 1'b1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Returns at the negedge inside the sof cycle; edge number is that of the commit edge.
    task automatic wait_sof(input string tag, input int exp_edge);
        bit found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            found = sof;
        end
        check({tag, "_seen"}, int'(found), 1);
        if (exp_edge > 0) check({tag, "_edge"}, edge_cnt + 1, exp_edge);
    endtask

    // Called in the sof cycle; counts high clks per channel from the commit edge on.
    task automatic measure_frame(input int drop_ch, input int drop_at);
        for (int c = 0; c < 4; c++) hi_len[c] = 0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        for (int n = 0; n < 200 && pwm_out != 4'b0; n++) begin
            for (int c = 0; c < 4; c++) if (pwm_out[c]) hi_len[c]++;
            if (n + 1 == drop_at) ch_en[drop_ch] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_lens(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
        check({tag, "_ch0"}, hi_len[0], e0);
        check({tag, "_ch1"}, hi_len[1], e1);
        check({tag, "_ch2"}, hi_len[2], e2);
        check({tag, "_ch3"}, hi_len[3], e3);
    endtask

    task automatic wr(input int ch, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = 2'(ch);
        bus.wr_data = 12'(data);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got sim time limit expected self-finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        ch_en        = 4'hF;
        io_enb       = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_ch    = '0;
        bus.wr_data  = '0;
        bus3.wr_en   = 1'b0;
        bus3.wr_ch   = '0;
        bus3.wr_data = '0;

        repeat (3) @(negedge clk);
        check("rst_sof",    int'(sof),       0);
        check("rst_active", int'(ch_active), 0);
        check("rst_pwm",    int'(pwm_out),   0);
        check("rst_oe",     int'(pwm_oe),    0);
        rst = 1'b0;

        // Index 3 does not exist in the 3-channel bank.
        bus3.wr_en   = 1'b1;
        bus3.wr_ch   = 2'd3;
        bus3.wr_data = 12'd5;
        @(negedge clk);
        bus3.wr_en   = 1'b0;

        wait_sof("sof0", 4);
        measure_frame(0, 0);
        check_lens("f0", 0, 0, 0, 0);
        check("f0_active",  int'(ch_active),  15);
        check("f0_oe",      int'(pwm_oe),     15);
        check("f0_active3", int'(ch_active3), 7);

        wr(2, 10);
        wait_sof("sof1", 204);
        measure_frame(0, 0);
        check_lens("f1", 0, 0, 40, 0);

        // Write landing on the commit edge must wait a frame.
        wait_sof("sof2", 404);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = 2'd1;
        bus.wr_data = 12'd7;
        measure_frame(0, 0);
        check_lens("f2", 0, 0, 40, 0);
        wait_sof("sof3", 604);
        measure_frame(0, 0);
        check_lens("f3", 0, 28, 40, 0);

        wr(0, 80);
        wr(3, 20);
        wait_sof("sof4", 804);
        measure_frame(0, 0);
        check_lens("f4", 196, 28, 40, 80);
        wait_sof("sof5", 1004);
        check("sof5_pwm_low", int'(pwm_out), 0);

        measure_frame(3, 10);
        check_lens("f5", 196, 28, 40, 80);
        wait_sof("sof6", 1204);
        measure_frame(0, 0);
        check_lens("f6", 196, 28, 40, 0);
        check("f6_active", int'(ch_active), 7);
        check("f6_oe",     int'(pwm_oe),    7);

        io_enb = 1'b0;
        check("oe_before_edge", int'(pwm_oe), 7);
        @(negedge clk);
        check("oe_off", int'(pwm_oe), 0);
        io_enb = 1'b1;
        @(negedge clk);
        check("oe_hold", int'(pwm_oe), 0);
        wait_sof("sof7", 1404);
        @(negedge clk);
        check("oe_resume", int'(pwm_oe), 7);

        repeat (5) @(negedge clk);
        check("pre_rst_pwm", int'(pwm_out), 7);
        #2 rst = 1'b1;
        #1;
        check("rst_async_pwm",    int'(pwm_out),   0);
        check("rst_async_active", int'(ch_active), 0);
        check("rst_async_oe",     int'(pwm_oe),    0);
        @(negedge clk);
        rst = 1'b0;
        wait_sof("sof_rst", 4);
        measure_frame(0, 0);
        check_lens("r0", 0, 0, 0, 0);

        wr(0, 10);
        wait_sof("s0", 0);
        measure_frame(0, 0);
        check_lens("s0", 40, 0, 0, 0);
        wr(0, 45);
        wr(3, 45);
        ch_en[3] = 1'b1;
        w = 10;
        for (int k = 1; k <= 3; k++) begin
            if (SLEW) w = (w + SLEW_STEP < 45) ? w + SLEW_STEP : 45;
            else      w = 45;
            wait_sof($sformatf("s%0d", k), 0);
            measure_frame(0, 0);
            check($sformatf("slew%0d_ch0", k), hi_len[0], w * UI_DIV);
            check($sformatf("slew%0d_ch3", k), hi_len[3], 45 * UI_DIV);
        end

        check("oob_write_ignored", int'(seen3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
